// File: rtl/gate2_cell_if.sv
// gate2_cell_if: operand/result bundle for gate2_cell_unit.
// master drives in_valid/a/b/op/cin; slave returns the registered results.
interface gate2_cell_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic [WIDTH-1:0] y_and;
    logic [WIDTH-1:0] y_or;
    logic [WIDTH-1:0] y_xor;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             out_valid;

    modport master (
        output in_valid, a, b, op, cin,
        input  y_and, y_or, y_xor, y, cout, out_valid
    );

    modport slave (
        input  in_valid, a, b, op, cin,
        output y_and, y_or, y_xor, y, cout, out_valid
    );
endinterface

// File: rtl/gate2_cell_unit.sv
// gate2_cell_unit: per-lane AND/OR/XOR plus a gate-built ripple adder,
// all results registered with 1-cycle latency.
// Ports: clk, rst_n (sync, active-low), bus (gate2_cell_if.slave):
//   in: in_valid, a, b, op (00 AND/01 OR/10 XOR/11 ADD), cin
//   out: y_and, y_or, y_xor, y, cout, out_valid
module gate2_cell_unit #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    gate2_cell_if.slave bus
);
    logic [WIDTH-1:0] y_and_d, y_and_q;
    logic [WIDTH-1:0] y_or_d,  y_or_q;
    logic [WIDTH-1:0] y_xor_d, y_xor_q;
    logic [WIDTH-1:0] y_d,     y_q;
    logic             cout_d,  cout_q;
    logic             valid_d, valid_q;

    logic [WIDTH-1:0] g_and;
    logic [WIDTH-1:0] g_or;
    logic [WIDTH-1:0] g_xor;
    logic [WIDTH-1:0] g_sum;
    logic [WIDTH:0]   carry;

    // Ripple adder reuses the lane gates: p = a^b, c' = (c&p) | (a&b).
    always_comb begin
        g_and    = bus.a & bus.b;
        g_or     = bus.a | bus.b;
        g_xor    = bus.a ^ bus.b;
        g_sum    = '0;
        carry    = '0;
        carry[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            g_sum[i]   = g_xor[i] ^ carry[i];
            carry[i+1] = (carry[i] & g_xor[i]) | g_and[i];
        end
    end

    // Idle cycles hold the result registers, so inputs (even X) are
    // ignored unless in_valid is high.
    always_comb begin
        y_and_d = y_and_q;
        y_or_d  = y_or_q;
        y_xor_d = y_xor_q;
        y_d     = y_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            valid_d = 1'b1;
            y_and_d = g_and;
            y_or_d  = g_or;
            y_xor_d = g_xor;
            cout_d  = 1'b0;
            unique case (bus.op)
                2'b00: y_d = g_and;
                2'b01: y_d = g_or;
                2'b10: y_d = g_xor;
                default: begin
                    y_d    = g_sum;
                    cout_d = carry[WIDTH];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_and_q <= '0;
            y_or_q  <= '0;
            y_xor_q <= '0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            y_and_q <= y_and_d;
            y_or_q  <= y_or_d;
            y_xor_q <= y_xor_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.y_and     = y_and_q;
    assign bus.y_or      = y_or_q;
    assign bus.y_xor     = y_xor_q;
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_gate2_cell_unit.sv
// tb_gate2_cell_unit: directed + random checks of gate2_cell_unit
// against an arithmetic reference model.
module tb_gate2_cell_unit;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    gate2_cell_if #(.WIDTH(W)) bus ();

    gate2_cell_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what the outputs should show after the last edge.
    logic [W-1:0] m_and, m_or, m_xor, m_y;
    logic         m_cout, m_valid;

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge();
        logic [W:0] sum;
        if (!rst_n) begin
            m_and = '0; m_or = '0; m_xor = '0; m_y = '0;
            m_cout = 1'b0; m_valid = 1'b0;
        end else if (bus.in_valid === 1'b1) begin
            m_and = bus.a & bus.b;
            m_or  = bus.a | bus.b;
            m_xor = bus.a ^ bus.b;
            sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin};
            m_cout = 1'b0;
            case (bus.op)
                2'd0: m_y = m_and;
                2'd1: m_y = m_or;
                2'd2: m_y = m_xor;
                default: begin
                    m_y    = sum[W-1:0];
                    m_cout = sum[W];
                end
            endcase
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".y_and"}, 32'(bus.y_and), 32'(m_and));
        chk({tag, ".y_or"},  32'(bus.y_or),  32'(m_or));
        chk({tag, ".y_xor"}, 32'(bus.y_xor), 32'(m_xor));
        chk({tag, ".y"},     32'(bus.y),     32'(m_y));
        chk({tag, ".cout"},  32'(bus.cout),  32'(m_cout));
        chk({tag, ".ovld"},  32'(bus.out_valid), 32'(m_valid));
    endtask

    // Model the upcoming edge, take it, then sample 1 ns later.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] op,
                         input logic cin);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        bus.cin      = cin;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_and = '0; m_or = '0; m_xor = '0; m_y = '0;
        m_cout = 1'b0; m_valid = 1'b0;

        // Reset wins over a valid input.
        rst_n = 1'b0;
        drive(1'b1, 8'hFF, 8'h0F, 2'b11, 1'b1);
        tick("rst0");
        tick("rst1");
        chk("rst.y_lit", 32'(bus.y), 32'h0);

        // Truth table lanes.
        rst_n = 1'b1;
        drive(1'b1, 8'h0F, 8'h33, 2'b00, 1'b1);
        tick("tt");
        chk("tt.and_lit", 32'(bus.y_and), 32'h03);
        chk("tt.or_lit",  32'(bus.y_or),  32'h3F);
        chk("tt.xor_lit", 32'(bus.y_xor), 32'h3C);
        chk("tt.cout_lit", 32'(bus.cout), 32'h0);

        // Add wrap cases.
        drive(1'b1, 8'hFF, 8'h01, 2'b11, 1'b0);
        tick("add0");
        chk("add0.lit", 32'({bus.cout, bus.y}), 32'h100);
        drive(1'b1, 8'h7F, 8'h80, 2'b11, 1'b1);
        tick("add1");
        chk("add1.lit", 32'({bus.cout, bus.y}), 32'h100);

        // Hold with changing / unknown idle inputs.
        drive(1'b1, 8'hAA, 8'h55, 2'b10, 1'b1);
        tick("hold_acc");
        for (int i = 0; i < 3; i++) begin
            if (i == 2) drive(1'b0, 'x, 'x, 'x, 1'bx);
            else drive(1'b0, W'($urandom), W'($urandom), 2'b11, 1'b1);
            tick("hold");
            chk("hold.y_lit", 32'(bus.y), 32'hFF);
        end

        // Reset pulse between edges must not act.
        drive(1'b0, 8'h12, 8'h34, 2'b01, 1'b0);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("midrst.y", 32'(bus.y), 32'hFF);
        tick("midrst");

        // Streaming, with one reset edge in the middle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, W'($urandom), W'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom));
            rst_n = (i == 10) ? 1'b0 : 1'b1;
            tick("stream");
        end
        rst_n = 1'b1;

        // Random valid/idle mix.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom), W'($urandom), W'($urandom),
                  2'($urandom_range(0, 3)), 1'($urandom));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gate2_cell_unit.md
GATE2_CELL_UNIT -- requirements
Module: gate2_cell_unit

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand lane count; legal range 1..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  SHALL qualify a, b, op and cin for capture.
REQ-005 a  input  WIDTH  SHALL be operand A, one bit per gate lane.
REQ-006 b  input  WIDTH  SHALL be operand B, one bit per gate lane.
REQ-007 op  input  2  SHALL select the primary result: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-008 cin  input  1  SHALL be the carry-in, used only when op=11.
REQ-009 y_and  output  WIDTH  SHALL be the registered per-lane a AND b.
REQ-010 y_or  output  WIDTH  SHALL be the registered per-lane a OR b.
REQ-011 y_xor  output  WIDTH  SHALL be the registered per-lane a XOR b.
REQ-012 y  output  WIDTH  SHALL be the registered op-selected result.
REQ-013 cout  output  1  SHALL be the registered carry-out; 0 unless op=11.
REQ-014 out_valid  output  1  SHALL flag that the registered outputs hold a new result.

Function
REQ-015 Gate truth tables per lane SHALL be exact: AND is 1 only for 1,1; OR is 0 only for 0,0; XOR is 1 only when the inputs differ.
REQ-016 ADD SHALL be a WIDTH-bit ripple adder built only from these gates: p=a^b, s=p^c, c_next=(c&p)|(a&b), with lane 0 carry=cin.
REQ-017 For ADD, y SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of that sum.
REQ-018 On a clock edge with rst_n=1 and in_valid=1, all outputs SHALL update from the current inputs; latency is exactly 1 cycle.
REQ-019 On a clock edge with rst_n=1 and in_valid=0, y_and, y_or, y_xor, y and cout SHALL hold, and out_valid SHALL be 0.
REQ-020 out_valid SHALL be 1 in the cycle after every accepted input; back-to-back in_valid SHALL yield back-to-back results with no bubble.
REQ-021 y_and, y_or and y_xor SHALL be computed for every accepted input, independent of op.
REQ-022 For op other than 11, cout SHALL be registered as 0 and cin SHALL be ignored.
REQ-023 The block SHALL contain no combinational path from any input to any output.
REQ-024 X or Z values on inputs while in_valid=0 SHALL NOT affect the outputs.

Reset
REQ-025 When rst_n=0 at a rising clock edge, y_and, y_or, y_xor and y SHALL become all zeros, and cout and out_valid SHALL become 0.
REQ-026 Reset SHALL take priority over in_valid; an input presented in a reset cycle SHALL be discarded.
REQ-027 Reset asserted between clock edges SHALL have no effect until the next rising edge.
REQ-028 In the first edge with rst_n=1 and in_valid=1 after reset, the block SHALL accept the input normally.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles with in_valid=1, a=FF -> all outputs 0 and out_valid=0 after each edge.
REQ-030 Truth table: WIDTH=8, a=0F, b=33, op=00, in_valid=1 -> next cycle y_and=03, y_or=3F, y_xor=3C, y=03, cout=0, out_valid=1.
REQ-031 ADD wrap: a=FF, b=01, cin=0, op=11 -> y=00, cout=1; then a=7F, b=80, cin=1 -> y=00, cout=1.
REQ-032 Hold: accept a=AA, b=55, op=10, then in_valid=0 for 3 cycles with changing a and b -> y=FF held, out_valid=0.
REQ-033 Streaming: 16 consecutive random vectors with in_valid=1 -> each result matches the reference model one cycle later; out_valid stays 1.
REQ-034 Reset mid-stream: rst_n=0 for one edge during streaming -> outputs 0 that cycle; the next accepted vector produces a correct result.
